timer_ctrl: RTL and testbench

Programmable sequencer for the core's 8-bit event counter, sitting between the core's peripheral register port and the counter datapath. It owns the counter's enable, prescaling, compare/reload and one-shot/periodic sequencing, and it raises a level interrupt on compare match. Software configures it through a four-register request/ready port.

---
 rtl/timer_ctrl.sv | 175 +++++++++++++++++
 tb/tb_timer_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Purpose: sequences the 8-bit event counter: prescaler, compare/reload, one-shot/periodic, level irq.
// Latency: register access completes with a one-cycle ready pulse the cycle after acceptance.
// Backpressure: req is ignored while ready is high, so at most one access completes every 2 cycles.
module timer_ctrl #(
    parameter int PRESC_W = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic [7:0] rdata,
    output logic [7:0] count,
    output logic       running,
    output logic       irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] A_CTRL  = 2'd0;
    localparam logic [1:0] A_PRESC = 2'd1;
    localparam logic [1:0] A_CMP   = 2'd2;
    localparam logic [1:0] A_COUNT = 2'd3;

    state_t              state_q, state_d;
    logic [7:0]          count_q, count_d;
    logic [PRESC_W-1:0]  pres_cnt_q, pres_cnt_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [7:0]          cmp_q, cmp_d;
    logic                en_q, en_d;
    logic                periodic_q, periodic_d;
    logic                irq_en_q, irq_en_d;
    logic                pending_q, pending_d;
    logic                ready_q, ready_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                running_q, running_d;

    logic acc;
    logic wr_ctrl;
    logic wr_presc;
    logic wr_cmp;
    logic wr_clr;
    logic tick;
    logic match;

    // Decode the accepted access and the prescaler tick / compare match of this cycle.
    always_comb begin
        acc      = req & ~ready_q;
        wr_ctrl  = acc & we & (addr == A_CTRL);
        wr_presc = acc & we & (addr == A_PRESC);
        wr_cmp   = acc & we & (addr == A_CMP);
        wr_clr   = acc & we & (addr == A_COUNT);
        tick     = (state_q == ST_RUN) && (pres_cnt_q == presc_q);
        match    = tick && (count_q == cmp_q);
    end

    // Next-state: counting first, then register writes, so a CTRL write overrides a same-cycle tick.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pres_cnt_d = pres_cnt_q;
        presc_d    = presc_q;
        cmp_d      = cmp_q;
        en_d       = en_q;
        periodic_d = periodic_q;
        irq_en_d   = irq_en_q;
        pending_d  = pending_q;
        ready_d    = acc;
        rdata_d    = 8'h00;

        if (state_q == ST_RUN) begin
            pres_cnt_d = tick ? '0 : pres_cnt_q + PRESC_W'(1);
        end

        if (tick) begin
            if (match) begin
                if (periodic_q) begin
                    count_d = 8'h00;
                end else begin
                    // One-shot: count stays parked on the compare value.
                    state_d = ST_DONE;
                    en_d    = 1'b0;
                end
            end else begin
                count_d = count_q + 8'd1;
            end
        end

        // Set beats clear when a match and a CLR write coincide.
        if (match) begin
            pending_d = 1'b1;
        end else if (wr_clr) begin
            pending_d = 1'b0;
        end

        if (wr_presc) begin
            presc_d    = PRESC_W'(wdata);
            pres_cnt_d = '0;
        end

        if (wr_cmp) begin
            cmp_d = wdata;
        end

        if (wr_ctrl) begin
            en_d       = wdata[0];
            periodic_d = wdata[1];
            irq_en_d   = wdata[2];
            count_d    = count_q;
            if (wdata[0]) begin
                state_d    = ST_RUN;
                count_d    = 8'h00;
                pres_cnt_d = '0;
            end else begin
                state_d = ST_IDLE;
            end
        end

        running_d = (state_d == ST_RUN);

        // Reads return end-of-cycle values, so a same-cycle count update is visible.
        if (acc && !we) begin
            case (addr)
                A_CTRL:  rdata_d = {5'b00000, irq_en_d, periodic_d, en_d};
                A_PRESC: rdata_d = 8'(presc_d);
                A_CMP:   rdata_d = cmp_d;
                default: rdata_d = count_d;
            endcase
        end
    end

    // State and register file, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            count_q    <= 8'h00;
            pres_cnt_q <= '0;
            presc_q    <= '0;
            cmp_q      <= 8'hFF;
            en_q       <= 1'b0;
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            pending_q  <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= 8'h00;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pres_cnt_q <= pres_cnt_d;
            presc_q    <= presc_d;
            cmp_q      <= cmp_d;
            en_q       <= en_d;
            periodic_q <= periodic_d;
            irq_en_q   <= irq_en_d;
            pending_q  <= pending_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            running_q  <= running_d;
        end
    end

    assign ready   = ready_q;
    assign rdata   = rdata_q;
    assign count   = count_q;
    assign running = running_q;
    assign irq     = pending_q & irq_en_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Purpose: self-checking bench for timer_ctrl; read data is scoreboarded, counter/irq timing checked per cycle.
// Latency: outputs sampled 1 time unit after the rising edge; rdata sampled on the falling edge.
// Backpressure: the bus task waits out any ready pulse before presenting a new access.
module tb_timer_ctrl;

    logic       clk;
    logic       reset_n;
    logic       req;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       ready;
    logic [7:0] rdata;
    logic [7:0] count;
    logic       running;
    logic       irq;

    int checks   = 0;
    int failures = 0;
    int rdy_cnt  = 0;

    logic [7:0] sb_q[$];

    timer_ctrl #(.PRESC_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .ready   (ready),
        .rdata   (rdata),
        .count   (count),
        .running (running),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One register access; returns in the cycle where ready should be high.
    task automatic bus(input logic w, input logic [1:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
        int guard = 0;
        while (ready && guard < 8) begin
            cyc(1);
            guard++;
        end
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        sb_q.push_back(w ? 8'h00 : exp_rd);
        cyc(1);
        req = 1'b0;
        we  = 1'b0;
        check("bus_ready", int'(ready), 1);
    endtask

    // Response monitor: every ready pulse pops one expected rdata; rdata must be 0 otherwise.
    always @(negedge clk) begin
        if (ready) begin
            rdy_cnt++;
            if (sb_q.size() == 0) begin
                check("ready_without_request", int'(ready), 0);
            end else begin
                check("rdata", int'(rdata), int'(sb_q.pop_front()));
            end
        end else begin
            check("rdata_idle", int'(rdata), 0);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_c;
        int rc0;
        int guard;
        reset_n = 1'b0;
        req     = 1'b0;
        we      = 1'b0;
        addr    = 2'd0;
        wdata   = 8'h00;
        cyc(2);
        check("rst_count", int'(count), 0);
        check("rst_running", int'(running), 0);
        check("rst_irq", int'(irq), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_rdata", int'(rdata), 0);
        reset_n = 1'b1;
        cyc(1);

        // Reset asserted mid-count.
        bus(1'b1, 2'd1, 8'h00, 8'h00);
        bus(1'b1, 2'd2, 8'h05, 8'h00);
        bus(1'b1, 2'd0, 8'h01, 8'h00);
        check("midrst_start_count", int'(count), 0);
        cyc(3);
        check("midrst_count3", int'(count), 3);
        reset_n = 1'b0;
        #1;
        check("midrst_count", int'(count), 0);
        check("midrst_running", int'(running), 0);
        check("midrst_irq", int'(irq), 0);
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        bus(1'b0, 2'd2, 8'h00, 8'hFF);
        bus(1'b0, 2'd0, 8'h00, 8'h00);

        // Periodic, PRESC=0, CMP=3.
        bus(1'b1, 2'd1, 8'h00, 8'h00);
        bus(1'b1, 2'd2, 8'h03, 8'h00);
        bus(1'b1, 2'd0, 8'h07, 8'h00);
        check("per_running", int'(running), 1);
        check("per_count0", int'(count), 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            check("per_count", int'(count), k % 4);
            check("per_irq", int'(irq), int'(k >= 4));
        end
        bus(1'b1, 2'd3, 8'h00, 8'h00);
        check("per_clr_irq", int'(irq), 0);
        cyc(2);
        check("per_irq_before_next", int'(irq), 0);
        cyc(1);
        check("per_irq_next_period", int'(irq), 1);

        // One-shot with prescale.
        bus(1'b1, 2'd0, 8'h00, 8'h00);
        bus(1'b1, 2'd3, 8'h00, 8'h00);
        bus(1'b1, 2'd1, 8'h02, 8'h00);
        bus(1'b1, 2'd2, 8'h02, 8'h00);
        bus(1'b1, 2'd0, 8'h05, 8'h00);
        check("os_running", int'(running), 1);
        check("os_count0", int'(count), 0);
        check("os_irq0", int'(irq), 0);
        for (int k = 1; k <= 11; k++) begin
            cyc(1);
            exp_c = (k / 3 > 2) ? 2 : k / 3;
            check("os_count", int'(count), exp_c);
            check("os_running", int'(running), int'(k < 9));
            check("os_irq", int'(irq), int'(k >= 9));
        end
        bus(1'b0, 2'd0, 8'h00, 8'h04);
        bus(1'b0, 2'd3, 8'h00, 8'h02);

        // Clear colliding with a match every cycle.
        bus(1'b1, 2'd0, 8'h00, 8'h00);
        bus(1'b1, 2'd3, 8'h00, 8'h00);
        bus(1'b1, 2'd1, 8'h00, 8'h00);
        bus(1'b1, 2'd2, 8'h00, 8'h00);
        bus(1'b1, 2'd0, 8'h07, 8'h00);
        cyc(2);
        check("coll_irq_pre", int'(irq), 1);
        bus(1'b1, 2'd3, 8'h00, 8'h00);
        check("coll_irq_after_clr", int'(irq), 1);
        cyc(1);
        check("coll_irq_hold", int'(irq), 1);
        check("coll_count", int'(count), 0);
        bus(1'b0, 2'd3, 8'h00, 8'h00);

        // Stop at 7 and restart.
        bus(1'b1, 2'd0, 8'h00, 8'h00);
        bus(1'b1, 2'd3, 8'h00, 8'h00);
        bus(1'b1, 2'd2, 8'hFF, 8'h00);
        bus(1'b1, 2'd0, 8'h01, 8'h00);
        cyc(7);
        check("stop_count7", int'(count), 7);
        bus(1'b1, 2'd0, 8'h00, 8'h00);
        check("stop_running", int'(running), 0);
        check("stop_count_hold", int'(count), 7);
        cyc(3);
        check("stop_count_idle", int'(count), 7);
        bus(1'b0, 2'd3, 8'h00, 8'h07);
        bus(1'b1, 2'd0, 8'h05, 8'h00);
        check("restart_count", int'(count), 0);
        check("restart_running", int'(running), 1);

        // CMP lowered below count: wrap through 255 to reach it.
        cyc(10);
        check("wrap_count10", int'(count), 10);
        bus(1'b1, 2'd2, 8'h01, 8'h00);
        check("wrap_count11", int'(count), 11);
        for (int i = 1; i <= 247; i++) begin
            cyc(1);
            exp_c = (i <= 246) ? (11 + i) % 256 : 1;
            check("wrap_count", int'(count), exp_c);
            check("wrap_running", int'(running), int'(i <= 246));
            check("wrap_irq", int'(irq), int'(i >= 247));
        end
        bus(1'b0, 2'd0, 8'h00, 8'h04);

        // Back-to-back requests: ready only every second cycle.
        guard = 0;
        while (ready && guard < 8) begin
            cyc(1);
            guard++;
        end
        rc0   = rdy_cnt;
        req   = 1'b1;
        we    = 1'b0;
        addr  = 2'd2;
        for (int j = 0; j < 3; j++) sb_q.push_back(8'h01);
        for (int j = 1; j <= 6; j++) begin
            cyc(1);
            check("pace_ready", int'(ready), j % 2);
            if (j == 5) req = 1'b0;
        end
        check("pace_ready_count", rdy_cnt - rc0, 3);
        cyc(2);
        check("sb_drain", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
